// File: rtl/core_pkg.sv
// core_pkg: shared instruction word layout, idle value, FSM state encoding and tile geometry for core_ctrl
package core_pkg;
  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;
  localparam inst_t inst_idle = 34'h1_800C_0000;
  localparam logic [3:0] s_idle    = 4'd0;
  localparam logic [3:0] s_w_l0    = 4'd1;
  localparam logic [3:0] s_k_load  = 4'd2;
  localparam logic [3:0] s_k_drain = 4'd3;
  localparam logic [3:0] s_a_l0    = 4'd4;
  localparam logic [3:0] s_exec    = 4'd5;
  localparam logic [3:0] s_ofifo   = 4'd6;
  localparam logic [3:0] s_acc     = 4'd7;
  localparam logic [3:0] s_fin     = 4'd8;
  localparam int k_drain_len = 11;
  localparam int kw = 3;
  localparam int iw = 6;
  localparam int ow = 4;
endpackage

// File: rtl/core_if.sv
// core_if: controller bus; start/ofifo_valid in, inst/busy/done/kij out (slave = controller side)
interface core_if;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;
  modport slave (input start, ofifo_valid, output inst, busy, done, kij);
  modport master (output start, ofifo_valid, input inst, busy, done, kij);
endinterface

// File: rtl/phase_cnt.sv
// phase_cnt: loadable down-counter that holds at zero; tc flags the last cycle of a phase
// ports: clk, reset (async active-low), ld/ld_val load, en count enable, cnt value, tc terminal count
module phase_cnt #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         en,
  input  logic [w-1:0] ld_val,
  output logic [w-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (en && !tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: tile sequencer issuing per-cycle core instructions over all kernel taps, then accumulation
// ports: clk, reset (async active-low), c (core_if.slave: start, ofifo_valid in; inst, busy, done, kij out)
// inst for a cycle is decided from the previous cycle's state and ofifo_valid, then registered.
module core_ctrl
  import core_pkg::*;
#(
  parameter int          row      = 8,
  parameter int          col      = 8,
  parameter int          len_nij  = 36,
  parameter int          len_kij  = 9,
  parameter int          len_onij = 16,
  parameter logic [10:0] w_base   = 11'd1024
) (
  input  logic clk,
  input  logic reset,
  core_if.slave c
);
  logic [3:0] state, state_d, kij_d, o, o_d;
  logic [7:0] cnt, ld_val, tw, ta, tn, ca;
  logic       ld, en, tc, rd;
  inst_t      ins;
  phase_cnt #(.w(8)) u_cnt (.clk(clk), .reset(reset), .ld(ld), .en(en), .ld_val(ld_val), .cnt(cnt), .tc(tc));
  assign tw = 8'(col) - cnt;
  assign ta = 8'(len_nij) - cnt;
  assign tn = 8'(len_nij - 1) - cnt;
  assign ca = 8'(len_kij + 1) - cnt;
  assign rd = ca < 8'(len_kij);
  always_comb begin
    state_d = state;
    kij_d = c.kij;
    o_d = o;
    ld = 1'b0;
    ld_val = '0;
    en = 1'b1;
    case (state)
      s_idle: if (c.start) begin
        state_d = s_w_l0;
        kij_d = '0;
        ld = 1'b1;
        ld_val = 8'(col);
      end
      s_w_l0: if (tc) begin
        state_d = s_k_load;
        ld = 1'b1;
        ld_val = 8'(row + 2 * col - 1);
      end
      s_k_load: if (tc) begin
        state_d = s_k_drain;
        ld = 1'b1;
        ld_val = 8'(k_drain_len - 1);
      end
      s_k_drain: if (tc) begin
        state_d = s_a_l0;
        ld = 1'b1;
        ld_val = 8'(len_nij);
      end
      s_a_l0: if (tc) begin
        state_d = s_exec;
        ld = 1'b1;
        ld_val = 8'(len_nij + row + col - 1);
      end
      s_exec: if (tc) begin
        state_d = s_ofifo;
        ld = 1'b1;
        ld_val = 8'(len_nij - 1);
      end
      s_ofifo: begin
        en = c.ofifo_valid;
        if (c.ofifo_valid && tc) begin
          ld = 1'b1;
          state_d = c.kij < 4'(len_kij - 1) ? s_w_l0 : s_acc;
          kij_d = c.kij < 4'(len_kij - 1) ? c.kij + 4'd1 : c.kij;
          ld_val = c.kij < 4'(len_kij - 1) ? 8'(col) : 8'(len_kij + 1);
          o_d = '0;
        end
      end
      s_acc: if (tc) begin
        ld = o != 4'(len_onij - 1);
        ld_val = 8'(len_kij + 1);
        state_d = ld ? s_acc : s_fin;
        o_d = ld ? o + 4'd1 : o;
      end
      s_fin: begin
        state_d = s_idle;
        kij_d = '0;
      end
      default: state_d = s_idle;
    endcase
  end
  always_comb begin
    ins = inst_idle;
    case (state)
      s_w_l0: begin
        ins.cen_xmem = 1'b0;
        ins.a_xmem = 11'(w_base + c.kij * col + tw);
        ins.ififo_wr = |tw;
      end
      s_k_load: begin
        ins.ififo_rd = 1'b1;
        ins.load = 1'b1;
      end
      s_k_drain: ins.load = 1'b1;
      s_a_l0: begin
        ins.cen_xmem = 1'b0;
        ins.a_xmem = 11'(ta);
        ins.l0_wr = |ta;
      end
      s_exec: begin
        ins.l0_rd = 1'b1;
        ins.execute = 1'b1;
      end
      s_ofifo: if (c.ofifo_valid) begin
        ins.ofifo_rd = 1'b1;
        ins.cen_pmem = 1'b0;
        ins.wen_pmem = 1'b0;
        ins.a_pmem = 11'(c.kij * len_nij + tn);
      end
      s_acc: begin
        ins.cen_pmem = !rd;
        ins.a_pmem = rd ? 11'(ca * len_nij + (o / ow + ca / kw) * iw + o % ow + ca % kw) : '0;
        ins.acc = |ca && ca <= 8'(len_kij);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= s_idle;
      o <= '0;
      c.kij <= '0;
      c.inst <= inst_idle;
      c.busy <= 1'b0;
      c.done <= 1'b0;
    end else begin
      state <= state_d;
      o <= o_d;
      c.kij <= kij_d;
      c.inst <= ins;
      c.busy <= (state_d != s_idle) || (state == s_fin);
      c.done <= state == s_fin;
    end
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed self-checking bench for core_ctrl
module tb_core_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  core_if bus();
  core_ctrl dut (.clk(clk), .reset(reset), .c(bus));
  always #5 clk = ~clk;
  localparam logic [33:0] idle_i = 34'h1_800C_0000;
  int n_tests = 0;
  int n_fail = 0;
  logic [33:0] i;
  logic        acc, cen_p, wen_p, cen_x, ofifo_rd, ififo_wr, ififo_rd, execute;
  logic [10:0] a_p, a_x;
  assign i = bus.inst;
  assign acc = i[33];
  assign cen_p = i[32];
  assign wen_p = i[31];
  assign a_p = i[30:20];
  assign cen_x = i[19];
  assign a_x = i[17:7];
  assign ofifo_rd = i[6];
  assign ififo_wr = i[5];
  assign ififo_rd = i[4];
  assign execute = i[1];
  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int wblk, wn0, writes, reads, accs, dones, ex1, ex2, tog, poke, post;
  int wstart[9];
  int w0a[9];
  logic w0wr[9];
  int rda[144];
  logic [33:0] obs[4];
  logic pat[4];
  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", i, idle_i);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_kij", bus.kij, 0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_inst", i, idle_i);
      chk("idle_busy_kij", {bus.busy, bus.kij}, 0);
    end
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
    for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
      @(negedge clk);
      if (!cen_x && a_x >= 11'd1024) begin
        if (!ififo_wr) begin
          if (wblk < 9) wstart[wblk] = int'(a_x);
          if (wblk == 3) chk("kij_at_w3", bus.kij, 3);
          wblk++;
        end
        if (wblk == 1 && wn0 < 9) begin
          w0a[wn0] = int'(a_x);
          w0wr[wn0] = ififo_wr;
          wn0++;
        end
      end
      if (!cen_p && !wen_p) writes++;
      if (!cen_p && wen_p) begin
        if (reads < 144) rda[reads] = int'(a_p);
        reads++;
      end
      if (acc) accs++;
      if (poke == 1) begin
        chk("kload_poke_kij", bus.kij, 0);
        chk("kload_poke_state", ififo_rd, 1);
        poke = 2;
      end
      bus.start = ififo_rd && poke == 0;
      if (bus.start) poke = 1;
      if (execute && bus.kij == 2) ex2++;
      if (tog > 0 && tog <= 4) obs[tog-1] = i;
      if (tog == 0 && ex2 == 52) tog = 1;
      else if (tog > 0 && tog <= 4) tog++;
      bus.ofifo_valid = (tog >= 1 && tog <= 4) ? pat[tog-1] : 1'b1;
      if (post > 0) post++;
      if (post == 2) chk("busy_fall", bus.busy, 0);
      if (bus.done) begin
        dones++;
        if (post == 0) begin
          chk("done_busy", bus.busy, 1);
          post = 1;
        end
      end
    end
    chk("done_seen", post > 0, 1);
    chk("done_count", dones, 1);
    chk("w_blocks", wblk, 9);
    chk("w_start0", wstart[0], 1024);
    chk("w_start3", wstart[3], 1048);
    chk("w_start8", wstart[8], 1088);
    for (int t = 0; t < 9; t++) chk("w0_addr", w0a[t], 1024 + t);
    chk("w0_wr_first", w0wr[0], 0);
    chk("w0_wr_last", w0wr[8], 1);
    chk("tog_wr72", obs[0], 34'h0_048C_0040);
    chk("tog_stall1", obs[1], idle_i);
    chk("tog_stall2", obs[2], idle_i);
    chk("tog_wr73", obs[3], 34'h0_049C_0040);
    chk("pmem_writes", writes, 324);
    chk("acc_reads", reads, 144);
    chk("acc_cycles", accs, 144);
    chk("acc_o0_j0", rda[0], 0);
    chk("acc_o0_j1", rda[1], 37);
    chk("acc_o1_j0", rda[9], 1);
    chk("acc_o5_j4", rda[49], 158);
    chk("acc_o15_j8", rda[143], 323);
    chk("end_idle", i, idle_i);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 1000 && ex1 < 10; cyc++) begin
      @(negedge clk);
      if (execute && bus.kij == 1) ex1++;
    end
    chk("exec1_found", ex1, 10);
    reset = 1'b0;
    #1;
    chk("mid_rst_inst", i, idle_i);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_kij", bus.kij, 0);
    chk("mid_rst_done", bus.done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_inst", i, idle_i);
      chk("post_rst_busy", bus.busy, 0);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_busy", bus.busy, 1);
    @(negedge clk);
    chk("restart_w0", {cen_x, a_x}, {1'b0, 11'd1024});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
